// File: rtl/mvm_accum.sv
// Result-side collector for the dot8 pipeline: sums NUM_CHUNKS partial results per element,
// tags each element with its row index, and queues it in a first-word-fall-through FIFO.
module mvm_accum #(
  parameter int IWIDTH     = 32,
  parameter int OWIDTH     = 32,
  parameter int NUM_CHUNKS = 4,
  parameter int NUM_ROWS   = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int SLACK      = 6,
  localparam int ROW_W     = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int CHUNK_W   = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1,
  localparam int PTR_W     = $clog2(FIFO_DEPTH),
  localparam int ENT_W     = OWIDTH + ROW_W + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [IWIDTH-1:0] i_result,
  input  logic                     i_valid,
  output logic [OWIDTH-1:0]        o_data,
  output logic [ROW_W-1:0]         o_row,
  output logic                     o_last,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic                     o_stall,
  output logic                     o_err
);

  logic [CHUNK_W-1:0] chunk_q, chunk_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [OWIDTH-1:0]  acc_q, acc_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     count_q, count_d;
  logic               err_q;
  logic [ENT_W-1:0]   hold_q;
  logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];

  logic signed [OWIDTH-1:0] ext;
  logic [OWIDTH-1:0]        sum;
  logic                     last_chunk, last_row, push, pop, full, wr_en;
  logic [ENT_W-1:0]         head, wr_entry;

  assign ext        = OWIDTH'(i_result);
  assign last_chunk = (chunk_q == CHUNK_W'(NUM_CHUNKS - 1));
  assign last_row   = (row_q == ROW_W'(NUM_ROWS - 1));
  assign sum        = (chunk_q == '0) ? ext : acc_q + ext;
  assign push       = i_valid & last_chunk;
  assign full       = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign pop        = o_valid & o_ready;
  // When full, the write slot is the one being popped this cycle, so push+pop is safe.
  assign wr_en      = push & (~full | pop);
  assign wr_entry   = {sum, row_q, last_row};

  always_comb begin
    chunk_d = chunk_q;
    row_d   = row_q;
    acc_d   = acc_q;
    count_d = count_q;
    if (i_valid) begin
      acc_d = sum;
      if (last_chunk) begin
        chunk_d = '0;
        row_d   = last_row ? '0 : row_q + 1'b1;
      end else begin
        chunk_d = chunk_q + 1'b1;
      end
    end
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chunk_q  <= '0;
      row_q    <= '0;
      acc_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      hold_q   <= '0;
    end else begin
      chunk_q <= chunk_d;
      row_q   <= row_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        hold_q   <= head;
      end
      if (push & ~wr_en) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_entry;
  end

  // An empty FIFO presents the most recently popped element so o_data holds steady.
  assign head    = mem_q[rd_ptr_q];
  assign o_valid = (count_q != '0);
  assign {o_data, o_row, o_last} = o_valid ? head : hold_q;
  assign o_stall = (count_q >= (PTR_W+1)'(FIFO_DEPTH - SLACK));
  assign o_err   = err_q;

endmodule

// File: tb/tb_mvm_accum.sv
// Directed bench for mvm_accum (NUM_ROWS=3 so row wrap is quick to exercise).
module tb_mvm_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_result;
  logic        i_valid;
  logic [31:0] o_data;
  logic [1:0]  o_row;
  logic        o_last;
  logic        o_valid;
  logic        o_ready;
  logic        o_stall;
  logic        o_err;

  int checks = 0;
  int errors = 0;

  mvm_accum #(
    .IWIDTH(32), .OWIDTH(32), .NUM_CHUNKS(4), .NUM_ROWS(3), .FIFO_DEPTH(8), .SLACK(6)
  ) dut (
    .clk(clk), .rst(rst), .i_result(i_result), .i_valid(i_valid),
    .o_data(o_data), .o_row(o_row), .o_last(o_last), .o_valid(o_valid),
    .o_ready(o_ready), .o_stall(o_stall), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] d);
    i_valid  = v;
    i_result = d;
    @(posedge clk);
    #1;
    i_valid  = 1'b0;
    i_result = '0;
  endtask

  task automatic send_elem(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] d);
    step(1'b1, a);
    step(1'b1, b);
    step(1'b1, c);
    step(1'b1, d);
  endtask

  task automatic pop_one();
    o_ready = 1'b1;
    @(posedge clk);
    #1;
    o_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] d, input logic [1:0] r, input logic l);
    chk({tag, "_valid"}, 64'(o_valid), 64'd1);
    chk({tag, "_data"},  64'(o_data), 64'(d));
    chk({tag, "_row"},   64'(o_row), 64'(r));
    chk({tag, "_last"},  64'(o_last), 64'(l));
  endtask

  initial begin
    rst = 1'b0; i_valid = 1'b0; i_result = '0; o_ready = 1'b0;
    #3;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_data",  64'(o_data), 64'd0);
    chk("rst_row",   64'(o_row), 64'd0);
    chk("rst_last",  64'(o_last), 64'd0);
    chk("rst_stall", 64'(o_stall), 64'd0);
    chk("rst_err",   64'(o_err), 64'd0);
    #9 rst = 1'b1;
    @(posedge clk); #1;

    // Basic sum 1+2+3+4
    o_ready = 1'b1;
    step(1'b1, 32'd1);
    step(1'b1, 32'd2);
    step(1'b1, 32'd3);
    chk("basic_not_early", 64'(o_valid), 64'd0);
    step(1'b1, 32'd4);
    chk_head("basic", 32'd10, 2'd0, 1'b0);
    @(posedge clk); #1;
    o_ready = 1'b0;
    chk("basic_popped", 64'(o_valid), 64'd0);
    chk("basic_hold",   64'(o_data), 64'd10);

    // Signed chunks with idle gaps: -5+3-1+0 = -3
    step(1'b1, -32'sd5); step(1'b0, 32'd99);
    step(1'b1, 32'd3);   step(1'b0, 32'd99);
    step(1'b1, -32'sd1); step(1'b0, 32'd99);
    chk("sign_not_early", 64'(o_valid), 64'd0);
    step(1'b1, 32'd0);
    chk_head("sign", 32'hFFFF_FFFD, 2'd1, 1'b0);
    pop_one();
    step(1'b0, 32'd0);
    chk("sign_single", 64'(o_valid), 64'd0);

    // Row wrap over 3 rows, then a fourth element back at row 0
    do_reset();
    for (int k = 0; k < 3; k++) send_elem(32'd1, 32'd1, 32'd1, 32'd1);
    chk("wrap_stall", 64'(o_stall), 64'd1);
    for (int k = 0; k < 3; k++) begin
      chk_head($sformatf("wrap%0d", k), 32'd4, 2'(k), (k == 2));
      pop_one();
    end
    chk("wrap_empty",  64'(o_valid), 64'd0);
    chk("wrap_nostall", 64'(o_stall), 64'd0);
    send_elem(32'd1, 32'd1, 32'd1, 32'd1);
    chk_head("wrap3", 32'd4, 2'd0, 1'b0);
    pop_one();

    // Back-pressure: fill, overflow, drain
    do_reset();
    send_elem(32'd3, 32'd0, 32'd0, 32'd0);
    chk("bp_stall_occ1", 64'(o_stall), 64'd0);
    for (int k = 1; k < 8; k++) begin
      send_elem(32'(k * 10), 32'd1, 32'd1, 32'd1);
      if (k == 1) chk("bp_stall_occ2", 64'(o_stall), 64'd1);
    end
    chk("bp_err_before", 64'(o_err), 64'd0);
    send_elem(32'd80, 32'd1, 32'd1, 32'd1);
    chk("bp_err_after", 64'(o_err), 64'd1);
    for (int k = 0; k < 8; k++) begin
      chk_head($sformatf("bp%0d", k), 32'(k * 10 + 3), 2'(k % 3), (k % 3 == 2));
      pop_one();
    end
    chk("bp_drained", 64'(o_valid), 64'd0);
    chk("bp_err_sticky", 64'(o_err), 64'd1);

    // Full FIFO with same-cycle push and pop
    do_reset();
    for (int k = 0; k < 8; k++) send_elem(32'(k * 10), 32'd1, 32'd1, 32'd1);
    step(1'b1, 32'd80); step(1'b1, 32'd1); step(1'b1, 32'd1);
    o_ready = 1'b1;
    step(1'b1, 32'd1);
    o_ready = 1'b0;
    chk("fpp_err", 64'(o_err), 64'd0);
    for (int k = 1; k < 9; k++) begin
      chk_head($sformatf("fpp%0d", k), 32'(k * 10 + 3), 2'(k % 3), (k % 3 == 2));
      pop_one();
    end
    chk("fpp_drained", 64'(o_valid), 64'd0);

    // Reset in the middle of an element, with a queued element pending
    send_elem(32'd5, 32'd5, 32'd5, 32'd5);
    step(1'b1, 32'd7);
    step(1'b1, 32'd7);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(o_valid), 64'd0);
    chk("mid_rst_data",  64'(o_data), 64'd0);
    chk("mid_rst_row",   64'(o_row), 64'd0);
    chk("mid_rst_stall", 64'(o_stall), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    send_elem(32'd1, 32'd1, 32'd1, 32'd1);
    chk_head("mid", 32'd4, 2'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
